// File: rtl/video_timing_gen.sv
// Raster timing generator: walks (hcnt, vcnt) over the full frame and emits registered
// blank, sync, line/frame markers and a one-cycle-early pixel fetch request.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iENABLE,
    output logic [11:0] oX,
    output logic [11:0] oY,
    output logic        oBLANK,
    output logic [1:0]  oCTL,
    output logic        oLINE_START,
    output logic        oFRAME_START,
    output logic        oPIX_REQ
);

    localparam logic [11:0] HT_M1    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VT_M1    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0]  CTL_IDLE = {~VS_POL, ~HS_POL};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        blank_q, blank_d;
    logic [1:0]  ctl_q, ctl_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        pix_req_q, pix_req_d;
    logic [23:0] run_next;
    logic [23:0] look_next;

    // Raster successor of (h, v), packed as {h, v}.
    function automatic logic [23:0] next_pos(input logic [11:0] h, input logic [11:0] v);
        logic [11:0] nh;
        logic [11:0] nv;
        if (h == HT_M1) begin
            nh = 12'd0;
            nv = (v == VT_M1) ? 12'd0 : v + 12'd1;
        end else begin
            nh = h + 12'd1;
            nv = v;
        end
        return {nh, nv};
    endfunction

    always_comb begin
        state_d       = StIdle;
        hcnt_d        = 12'd0;
        vcnt_d        = 12'd0;
        blank_d       = 1'b1;
        ctl_d         = CTL_IDLE;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        pix_req_d     = 1'b0;
        run_next      = next_pos(hcnt_q, vcnt_q);
        look_next     = 24'd0;
        if (iENABLE) begin
            state_d = StRun;
            // Leaving IDLE always starts the raster at (0,0); no resume.
            if (state_q == StRun) begin
                hcnt_d = run_next[23:12];
                vcnt_d = run_next[11:0];
            end
            blank_d       = (hcnt_d >= H_ACT) || (vcnt_d >= V_ACT);
            ctl_d[0]      = (hcnt_d >= HS_START && hcnt_d < HS_END) ? HS_POL : ~HS_POL;
            ctl_d[1]      = (vcnt_d >= VS_START && vcnt_d < VS_END) ? VS_POL : ~VS_POL;
            line_start_d  = (hcnt_d == 12'd0);
            frame_start_d = (hcnt_d == 12'd0) && (vcnt_d == 12'd0);
            look_next     = next_pos(hcnt_d, vcnt_d);
            pix_req_d     = (look_next[23:12] < H_ACT) && (look_next[11:0] < V_ACT);
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q       <= StIdle;
            hcnt_q        <= 12'd0;
            vcnt_q        <= 12'd0;
            blank_q       <= 1'b1;
            ctl_q         <= CTL_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            blank_q       <= blank_d;
            ctl_q         <= ctl_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pix_req_q     <= pix_req_d;
        end
    end

    assign oX           = hcnt_q;
    assign oY           = vcnt_q;
    assign oBLANK       = blank_q;
    assign oCTL         = ctl_q;
    assign oLINE_START  = line_start_q;
    assign oFRAME_START = frame_start_q;
    // (0,0) is the next position whenever IDLE sees enable high, so request it right away.
    assign oPIX_REQ     = pix_req_q | (state_q == StIdle && iENABLE && !iRESET);

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default VGA instance plus a tiny-raster instance, both checked
// cycle by cycle against an index-based raster model through per-instance scoreboards.
module tb_video_timing_gen;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        blank;
        logic [1:0]  ctl;
        logic        ls;
        logic        fs;
        logic        pr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [11:0] d_x, d_y, s_x, s_y;
    logic        d_blank, d_ls, d_fs, d_pr, s_blank, s_ls, s_fs, s_pr;
    logic [1:0]  d_ctl, s_ctl;
    exp_t        got_d, got_s;

    exp_t q_d[$];
    exp_t q_s[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    video_timing_gen u_dut_def (
        .iCLK(clk), .iRESET(rst), .iENABLE(en),
        .oX(d_x), .oY(d_y), .oBLANK(d_blank), .oCTL(d_ctl),
        .oLINE_START(d_ls), .oFRAME_START(d_fs), .oPIX_REQ(d_pr)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_dut_small (
        .iCLK(clk), .iRESET(rst), .iENABLE(en),
        .oX(s_x), .oY(s_y), .oBLANK(s_blank), .oCTL(s_ctl),
        .oLINE_START(s_ls), .oFRAME_START(s_fs), .oPIX_REQ(s_pr)
    );

    assign got_d = {d_x, d_y, d_blank, d_ctl, d_ls, d_fs, d_pr};
    assign got_s = {s_x, s_y, s_blank, s_ctl, s_ls, s_fs, s_pr};

    // Expected outputs at raster index idx counted from (0,0).
    function automatic exp_t model(int ha, int hf, int hs, int hb, int va, int vf, int vs,
                                   int vb, bit hp, bit vp, int idx);
        exp_t e;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h  = idx % ht;
        int v  = (idx / ht) % vt;
        int nh = (idx + 1) % ht;
        int nv = ((idx + 1) / ht) % vt;
        e.x      = 12'(h);
        e.y      = 12'(v);
        e.blank  = (h >= ha) || (v >= va);
        e.ctl[0] = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        e.ctl[1] = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        e.ls     = (h == 0);
        e.fs     = (h == 0) && (v == 0);
        e.pr     = (nh < ha) && (nv < va);
        return e;
    endfunction

    function automatic exp_t model_d(int idx);
        return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, idx);
    endfunction

    function automatic exp_t model_s(int idx);
        return model(4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b0, idx);
    endfunction

    function automatic exp_t idle_exp(bit hp, bit vp, bit pr);
        exp_t e = '0;
        e.blank = 1'b1;
        e.ctl   = {!vp, !hp};
        e.pr    = pr;
        return e;
    endfunction

    function automatic string fmt(exp_t e);
        return $sformatf("x=%0d y=%0d blank=%0b ctl=%b ls=%0b fs=%0b pr=%0b",
                         e.x, e.y, e.blank, e.ctl, e.ls, e.fs, e.pr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        en  = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) step();
        rst = 1'b0;
        en  = 1'b1;
        repeat (300) step();
        // Asynchronous assertion mid-cycle, sampled before the next edge.
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        q_d.push_back(idle_exp(1'b0, 1'b0, 1'b0));
        q_s.push_back(idle_exp(1'b1, 1'b0, 1'b0));
        e = q_d.pop_front();
        n_cmp++;
        if (got_d !== e) begin
            n_bad++;
            $display("FAIL reset_async_def actual {%s} required {%s}", fmt(got_d), fmt(e));
        end
        e = q_s.pop_front();
        n_cmp++;
        if (got_s !== e) begin
            n_bad++;
            $display("FAIL reset_async_small actual {%s} required {%s}", fmt(got_s), fmt(e));
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            q_d.push_back(idle_exp(1'b0, 1'b0, 1'b0));
            q_s.push_back(idle_exp(1'b1, 1'b0, 1'b0));
            step();
            e = q_d.pop_front();
            n_cmp++;
            if (got_d !== e) begin
                n_bad++;
                $display("FAIL idle_hold_def cyc=%0d actual {%s} required {%s}",
                         i, fmt(got_d), fmt(e));
            end
            e = q_s.pop_front();
            n_cmp++;
            if (got_s !== e) begin
                n_bad++;
                $display("FAIL idle_hold_small cyc=%0d actual {%s} required {%s}",
                         i, fmt(got_s), fmt(e));
            end
        end
    endtask

    task automatic test_line_timing();
        exp_t e;
        int   hs_low = 0;
        int   ls_cnt = 0;
        restart();
        en = 1'b1;
        #1;
        q_d.push_back(idle_exp(1'b0, 1'b0, 1'b1));
        e = q_d.pop_front();
        n_cmp++;
        if (got_d !== e) begin
            n_bad++;
            $display("FAIL idle_prefetch actual {%s} required {%s}", fmt(got_d), fmt(e));
        end
        for (int i = 0; i < 1610; i++) begin
            q_d.push_back(model_d(i));
            step();
            e = q_d.pop_front();
            n_cmp++;
            if (got_d !== e) begin
                n_bad++;
                $display("FAIL line_timing idx=%0d actual {%s} required {%s}",
                         i, fmt(got_d), fmt(e));
            end
            if (i < 800 && d_ctl[0] == 1'b0) hs_low++;
            if (d_ls) ls_cnt++;
        end
        n_cmp++;
        if (hs_low !== 96) begin
            n_bad++;
            $display("FAIL hsync_width actual %0d required 96", hs_low);
        end
        n_cmp++;
        if (ls_cnt !== 3) begin
            n_bad++;
            $display("FAIL line_start_count actual %0d required 3", ls_cnt);
        end
    endtask

    task automatic test_small_frame();
        exp_t        e;
        logic [39:0] gold_blank = 40'hFF_FF_FF_F0_F0;
        int          last_fs = -1;
        int          fs_period = 0;
        int          hs_high = 0;
        restart();
        en = 1'b1;
        for (int i = 0; i < 121; i++) begin
            q_s.push_back(model_s(i));
            step();
            e = q_s.pop_front();
            n_cmp++;
            if (got_s !== e) begin
                n_bad++;
                $display("FAIL small_frame idx=%0d actual {%s} required {%s}",
                         i, fmt(got_s), fmt(e));
            end
            n_cmp++;
            if (s_blank !== gold_blank[i % 40]) begin
                n_bad++;
                $display("FAIL small_blank_table idx=%0d actual %0b required %0b",
                         i, s_blank, gold_blank[i % 40]);
            end
            if (i < 8 && s_ctl[0] == 1'b1) hs_high++;
            if (s_fs) begin
                if (last_fs >= 0) fs_period = i - last_fs;
                last_fs = i;
            end
        end
        n_cmp++;
        if (hs_high !== 2) begin
            n_bad++;
            $display("FAIL small_hsync_width actual %0d required 2", hs_high);
        end
        n_cmp++;
        if (fs_period !== 40) begin
            n_bad++;
            $display("FAIL small_frame_period actual %0d required 40", fs_period);
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        restart();
        en = 1'b1;
        for (int i = 0; i <= 1100; i++) begin
            q_d.push_back(model_d(i));
            step();
            e = q_d.pop_front();
            n_cmp++;
            if (got_d !== e) begin
                n_bad++;
                $display("FAIL drop_run idx=%0d actual {%s} required {%s}",
                         i, fmt(got_d), fmt(e));
            end
        end
        // Now at (300,1): drop enable for a few cycles.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_d.push_back(idle_exp(1'b0, 1'b0, 1'b0));
            step();
            e = q_d.pop_front();
            n_cmp++;
            if (got_d !== e) begin
                n_bad++;
                $display("FAIL drop_idle cyc=%0d actual {%s} required {%s}",
                         i, fmt(got_d), fmt(e));
            end
        end
        en = 1'b1;
        #1;
        q_d.push_back(idle_exp(1'b0, 1'b0, 1'b1));
        e = q_d.pop_front();
        n_cmp++;
        if (got_d !== e) begin
            n_bad++;
            $display("FAIL reenable_prefetch actual {%s} required {%s}", fmt(got_d), fmt(e));
        end
        for (int i = 0; i < 6; i++) begin
            q_d.push_back(model_d(i));
            step();
            e = q_d.pop_front();
            n_cmp++;
            if (got_d !== e) begin
                n_bad++;
                $display("FAIL restart idx=%0d actual {%s} required {%s}",
                         i, fmt(got_d), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_small_frame();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
